// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - bus bundle between requesters, arbiter and main memory
//
// Purpose: groups the I-cache, D-cache and memory-side signals of mem_arbiter.
//   slave  : the arbiter's view (takes requests/memory responses, drives beats)
//   master : the environment's view (caches plus memory model)
// Ports (arbiter view):
//   in  ic_req, ic_addr[31:0]                  I-cache line-fill request
//   in  dc_req, dc_we, dc_addr[31:0], dc_wdata  D-cache fill/writeback request
//   in  mem_ready, mem_rdata[31:0]              memory beat completion / read word
//   out mem_req, mem_we, mem_addr, mem_wdata    memory beat request
//   out ic_grant, dc_grant                      current owner of the memory port
//   out beat_valid, beat_idx, rdata             forwarded read beat
//   out ic_done, dc_done                        one-cycle completion pulses
interface mem_arbiter_if #(
   parameter int LINE_WORDS = 8
);
   localparam int IDX_W = $clog2(LINE_WORDS);

   logic             ic_req;
   logic [31:0]      ic_addr;
   logic             dc_req;
   logic             dc_we;
   logic [31:0]      dc_addr;
   logic [31:0]      dc_wdata;
   logic             mem_ready;
   logic [31:0]      mem_rdata;
   logic             mem_req;
   logic             mem_we;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic             ic_grant;
   logic             dc_grant;
   logic             beat_valid;
   logic [IDX_W-1:0] beat_idx;
   logic [31:0]      rdata;
   logic             ic_done;
   logic             dc_done;

   modport slave (
      input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ready, mem_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, ic_grant, dc_grant,
             beat_valid, beat_idx, rdata, ic_done, dc_done
   );

   modport master (
      output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ready, mem_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, ic_grant, dc_grant,
             beat_valid, beat_idx, rdata, ic_done, dc_done
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin I/D cache line-burst arbiter onto one memory port
//
// Purpose: grants the single memory port to the I-cache or D-cache for a whole
//   LINE_WORDS-beat line transfer, alternating on conflicts, then pulses done.
// Ports:
//   CLK    in  single clock, rising edge
//   RST_N  in  asynchronous active-low reset
//   bus    mem_arbiter_if.slave (requests, memory handshake, grants, beats, done)
module mem_arbiter #(
   parameter int LINE_WORDS = 8
) (
   input  logic        CLK,
   input  logic        RST_N,
   mem_arbiter_if.slave bus
);
   localparam int IDX_W  = $clog2(LINE_WORDS);
   localparam int BASE_W = 32 - IDX_W - 2;
   localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);
   localparam logic LS_I = 1'b0;
   localparam logic LS_D = 1'b1;

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  beat_q;
   logic [BASE_W-1:0] base_q;
   logic              we_q;
   logic              last_q;    // requester granted most recently
   logic              grant_i;   // IDLE arbitration picks I this cycle
   logic              grant_d;   // IDLE arbitration picks D this cycle
   logic              serving;
   logic              write_beat;
   logic              beat_end;  // final beat of the line completes this cycle

   // Word-offset bits of the request addresses are irrelevant: bursts always
   // start at the line base.
   wire unused_addr_bits = &{1'b0, bus.ic_addr[IDX_W+1:0], bus.dc_addr[IDX_W+1:0]};

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      grant_i = 1'b0;
      grant_d = 1'b0;
      case (state_q)
         IDLE: begin
            // On conflict the requester not served last wins.
            if (bus.ic_req && (!bus.dc_req || last_q == LS_D)) begin
               grant_i = 1'b1;
               state_d = SERVE_I;
            end else if (bus.dc_req) begin
               grant_d = 1'b1;
               state_d = SERVE_D;
            end
         end
         SERVE_I, SERVE_D: begin
            if (beat_end) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         beat_q <= '0;
         base_q <= '0;
         we_q   <= 1'b0;
         last_q <= LS_D;
      end else if (grant_i) begin
         beat_q <= '0;
         base_q <= bus.ic_addr[31:IDX_W+2];
         we_q   <= 1'b0;
         last_q <= LS_I;
      end else if (grant_d) begin
         beat_q <= '0;
         base_q <= bus.dc_addr[31:IDX_W+2];
         we_q   <= bus.dc_we;
         last_q <= LS_D;
      end else if (serving && bus.mem_ready) begin
         beat_q <= beat_end ? '0 : beat_q + IDX_W'(1);
      end
   end

   assign serving    = (state_q == SERVE_I) || (state_q == SERVE_D);
   assign write_beat = (state_q == SERVE_D) && we_q;
   assign beat_end   = serving && bus.mem_ready && (beat_q == LAST_BEAT);

   // All memory-side outputs are gated by state so reset zeroes them at once.
   assign bus.mem_req    = serving;
   assign bus.mem_we     = write_beat;
   assign bus.mem_addr   = serving ? {base_q, beat_q, 2'b00} : 32'h0;
   assign bus.mem_wdata  = write_beat ? bus.dc_wdata : 32'h0;
   assign bus.ic_grant   = (state_q == SERVE_I);
   assign bus.dc_grant   = (state_q == SERVE_D);
   assign bus.beat_valid = serving && !write_beat && bus.mem_ready;
   assign bus.beat_idx   = beat_q;
   assign bus.rdata      = bus.beat_valid ? bus.mem_rdata : 32'h0;
   // last_q still names the requester whose burst just finished.
   assign bus.ic_done    = (state_q == DONE) && (last_q == LS_I);
   assign bus.dc_done    = (state_q == DONE) && (last_q == LS_D);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   logic wd_auto = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   mem_arbiter_if #(.LINE_WORDS(8)) bus ();
   mem_arbiter #(.LINE_WORDS(8)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

   always #5 CLK = ~CLK;

   // Memory returns a word derived from its address; writeback data follows beat_idx.
   assign bus.mem_rdata = bus.mem_addr ^ 32'hC0DE_0000;
   assign bus.dc_wdata  = wd_auto ? (32'hA0 + 32'(bus.beat_idx)) : 32'h0;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      bus.ic_req = 0; bus.ic_addr = 0; bus.dc_req = 0; bus.dc_we = 0;
      bus.dc_addr = 0; bus.mem_ready = 1;
      RST_N = 0;
      step();
      @(negedge CLK);
      if (bus.mem_req !== 1'b0) begin $display("FAIL reset_mem_req: got %0h want 0", bus.mem_req); n_bad++; end n_cmp++;
      if ({bus.ic_grant, bus.dc_grant} !== 2'b00) begin $display("FAIL reset_grants: got %b want 00", {bus.ic_grant, bus.dc_grant}); n_bad++; end n_cmp++;
      if (bus.mem_addr !== 32'h0) begin $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); n_bad++; end n_cmp++;
      if (bus.mem_wdata !== 32'h0) begin $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); n_bad++; end n_cmp++;
      if (bus.rdata !== 32'h0) begin $display("FAIL reset_rdata: got %h want 0", bus.rdata); n_bad++; end n_cmp++;
      if ({bus.beat_valid, bus.ic_done, bus.dc_done, bus.mem_we} !== 4'b0) begin $display("FAIL reset_flags: got %b want 0000", {bus.beat_valid, bus.ic_done, bus.dc_done, bus.mem_we}); n_bad++; end n_cmp++;
      if (bus.beat_idx !== 3'd0) begin $display("FAIL reset_beat_idx: got %0d want 0", bus.beat_idx); n_bad++; end n_cmp++;
      step();
      RST_N = 1;
      bus.mem_ready = 0;
   endtask

   task automatic test_single_fill();
      bus.ic_req = 1; bus.ic_addr = 32'h0000_1234; bus.mem_ready = 1;
      @(negedge CLK);
      if (bus.mem_req !== 1'b0) begin $display("FAIL fill_pre_grant_req: got %0h want 0", bus.mem_req); n_bad++; end n_cmp++;
      step();
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         if (bus.ic_grant !== 1'b1 || bus.dc_grant !== 1'b0) begin $display("FAIL fill_grant beat %0d: got ic=%b dc=%b want ic=1 dc=0", k, bus.ic_grant, bus.dc_grant); n_bad++; end n_cmp++;
         if (bus.mem_addr !== 32'h1220 + 32'(4*k)) begin $display("FAIL fill_addr beat %0d: got %h want %h", k, bus.mem_addr, 32'h1220 + 32'(4*k)); n_bad++; end n_cmp++;
         if (bus.beat_valid !== 1'b1 || bus.mem_we !== 1'b0) begin $display("FAIL fill_valid beat %0d: got valid=%b we=%b want valid=1 we=0", k, bus.beat_valid, bus.mem_we); n_bad++; end n_cmp++;
         if (bus.rdata !== ((32'h1220 + 32'(4*k)) ^ 32'hC0DE_0000)) begin $display("FAIL fill_rdata beat %0d: got %h want %h", k, bus.rdata, (32'h1220 + 32'(4*k)) ^ 32'hC0DE_0000); n_bad++; end n_cmp++;
         if (bus.beat_idx !== 3'(k)) begin $display("FAIL fill_beat_idx: got %0d want %0d", bus.beat_idx, k); n_bad++; end n_cmp++;
         step();
      end
      @(negedge CLK);
      if (bus.ic_done !== 1'b1 || bus.dc_done !== 1'b0) begin $display("FAIL fill_done: got ic=%b dc=%b want ic=1 dc=0", bus.ic_done, bus.dc_done); n_bad++; end n_cmp++;
      if (bus.mem_req !== 1'b0 || bus.ic_grant !== 1'b0) begin $display("FAIL fill_done_idle_bus: got req=%b grant=%b want 0 0", bus.mem_req, bus.ic_grant); n_bad++; end n_cmp++;
      bus.ic_req = 0;
      step();
      @(negedge CLK);
      if (bus.ic_done !== 1'b0) begin $display("FAIL fill_done_one_cycle: got %b want 0", bus.ic_done); n_bad++; end n_cmp++;
      bus.mem_ready = 0;
   endtask

   task automatic test_round_robin();
      RST_N = 0;
      step();
      RST_N = 1;
      bus.ic_req = 1; bus.ic_addr = 32'h0000_0100;
      bus.dc_req = 1; bus.dc_we = 0; bus.dc_addr = 32'h0000_2000; bus.mem_ready = 1;
      step();
      @(negedge CLK);
      if ({bus.ic_grant, bus.dc_grant} !== 2'b10) begin $display("FAIL rr_first_grant: got %b want 10", {bus.ic_grant, bus.dc_grant}); n_bad++; end n_cmp++;
      repeat (8) step();
      @(negedge CLK);
      if ({bus.ic_done, bus.dc_done} !== 2'b10) begin $display("FAIL rr_first_done: got %b want 10", {bus.ic_done, bus.dc_done}); n_bad++; end n_cmp++;
      step();
      @(negedge CLK);
      if (bus.mem_req !== 1'b0) begin $display("FAIL rr_idle_gap: got %b want 0", bus.mem_req); n_bad++; end n_cmp++;
      step();
      @(negedge CLK);
      if ({bus.ic_grant, bus.dc_grant} !== 2'b01) begin $display("FAIL rr_second_grant: got %b want 01", {bus.ic_grant, bus.dc_grant}); n_bad++; end n_cmp++;
      if (bus.mem_addr !== 32'h0000_2000) begin $display("FAIL rr_second_addr: got %h want 00002000", bus.mem_addr); n_bad++; end n_cmp++;
      repeat (8) step();
      @(negedge CLK);
      if ({bus.ic_done, bus.dc_done} !== 2'b01) begin $display("FAIL rr_second_done: got %b want 01", {bus.ic_done, bus.dc_done}); n_bad++; end n_cmp++;
      step();
      step();
      @(negedge CLK);
      if ({bus.ic_grant, bus.dc_grant} !== 2'b10) begin $display("FAIL rr_third_grant: got %b want 10", {bus.ic_grant, bus.dc_grant}); n_bad++; end n_cmp++;
      bus.ic_req = 0; bus.dc_req = 0;
      repeat (8) step();
      step();
      bus.mem_ready = 0;
   endtask

   task automatic test_writeback();
      bus.dc_req = 1; bus.dc_we = 1; bus.dc_addr = 32'h0000_8000; wd_auto = 1;
      step();
      for (int c = 0; c < 16; c++) begin
         bus.mem_ready = (c % 2 == 0);
         @(negedge CLK);
         if (c < 15) begin
            if (bus.mem_we !== 1'b1 || bus.dc_grant !== 1'b1) begin $display("FAIL wb_we cycle %0d: got we=%b grant=%b want 1 1", c, bus.mem_we, bus.dc_grant); n_bad++; end n_cmp++;
            if (bus.mem_addr !== 32'h8000 + 32'(4*((c+1)/2))) begin $display("FAIL wb_addr cycle %0d: got %h want %h", c, bus.mem_addr, 32'h8000 + 32'(4*((c+1)/2))); n_bad++; end n_cmp++;
            if (bus.mem_wdata !== 32'hA0 + 32'((c+1)/2)) begin $display("FAIL wb_wdata cycle %0d: got %h want %h", c, bus.mem_wdata, 32'hA0 + 32'((c+1)/2)); n_bad++; end n_cmp++;
            if (bus.beat_valid !== 1'b0 || bus.rdata !== 32'h0) begin $display("FAIL wb_no_read cycle %0d: got valid=%b rdata=%h want 0 0", c, bus.beat_valid, bus.rdata); n_bad++; end n_cmp++;
            if (bus.dc_done !== 1'b0) begin $display("FAIL wb_early_done cycle %0d: got %b want 0", c, bus.dc_done); n_bad++; end n_cmp++;
         end else begin
            if (bus.dc_done !== 1'b1 || bus.mem_req !== 1'b0) begin $display("FAIL wb_done: got done=%b req=%b want 1 0", bus.dc_done, bus.mem_req); n_bad++; end n_cmp++;
            bus.dc_req = 0; bus.dc_we = 0;
         end
         step();
      end
      wd_auto = 0;
      bus.mem_ready = 0;
   endtask

   task automatic test_reset_mid_burst();
      bus.dc_req = 1; bus.dc_we = 0; bus.dc_addr = 32'h0000_4000; bus.mem_ready = 1;
      step();
      repeat (3) step();
      @(negedge CLK);
      if (bus.beat_idx !== 3'd3) begin $display("FAIL rst_mid_beat: got %0d want 3", bus.beat_idx); n_bad++; end n_cmp++;
      RST_N = 0;
      #1;
      if ({bus.mem_req, bus.dc_grant} !== 2'b00) begin $display("FAIL rst_mid_abort: got req/grant %b want 00", {bus.mem_req, bus.dc_grant}); n_bad++; end n_cmp++;
      if (bus.mem_addr !== 32'h0 || bus.beat_idx !== 3'd0) begin $display("FAIL rst_mid_clear: got addr=%h beat=%0d want 0 0", bus.mem_addr, bus.beat_idx); n_bad++; end n_cmp++;
      for (int k = 0; k < 2; k++) begin
         step();
         @(negedge CLK);
         if (bus.dc_done !== 1'b0) begin $display("FAIL rst_mid_no_done: got %b want 0", bus.dc_done); n_bad++; end n_cmp++;
      end
      step();
      RST_N = 1;
      @(negedge CLK);
      if (bus.mem_req !== 1'b0) begin $display("FAIL rst_release_idle: got %b want 0", bus.mem_req); n_bad++; end n_cmp++;
      step();
      @(negedge CLK);
      if (bus.dc_grant !== 1'b1 || bus.beat_idx !== 3'd0 || bus.mem_addr !== 32'h4000) begin $display("FAIL rst_restart: got grant=%b beat=%0d addr=%h want 1 0 00004000", bus.dc_grant, bus.beat_idx, bus.mem_addr); n_bad++; end n_cmp++;
      repeat (8) step();
      @(negedge CLK);
      if (bus.dc_done !== 1'b1) begin $display("FAIL rst_restart_done: got %b want 1", bus.dc_done); n_bad++; end n_cmp++;
      bus.dc_req = 0;
      step();
      bus.mem_ready = 0;
   endtask

   task automatic test_drop_req();
      int dones = 0;
      bus.ic_req = 1; bus.ic_addr = 32'h0000_3000; bus.mem_ready = 1;
      step();
      repeat (2) step();
      bus.ic_req = 0;
      for (int k = 2; k < 8; k++) begin
         @(negedge CLK);
         if (bus.ic_grant !== 1'b1 || bus.mem_addr !== 32'h3000 + 32'(4*k)) begin $display("FAIL drop_continue beat %0d: got grant=%b addr=%h want 1 %h", k, bus.ic_grant, bus.mem_addr, 32'h3000 + 32'(4*k)); n_bad++; end n_cmp++;
         step();
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         if (bus.ic_done === 1'b1) dones++;
         step();
      end
      if (dones != 1) begin $display("FAIL drop_done_count: got %0d want 1", dones); n_bad++; end n_cmp++;
      @(negedge CLK);
      if (bus.mem_req !== 1'b0 || bus.ic_grant !== 1'b0) begin $display("FAIL drop_back_idle: got req=%b grant=%b want 0 0", bus.mem_req, bus.ic_grant); n_bad++; end n_cmp++;
      bus.mem_ready = 0;
   endtask

   task automatic test_idle_ready();
      bus.ic_req = 0; bus.dc_req = 0; bus.mem_ready = 1;
      for (int k = 0; k < 2; k++) begin
         @(negedge CLK);
         if (bus.beat_valid !== 1'b0 || bus.rdata !== 32'h0) begin $display("FAIL idle_ready_valid: got valid=%b rdata=%h want 0 0", bus.beat_valid, bus.rdata); n_bad++; end n_cmp++;
         if ({bus.mem_req, bus.ic_grant, bus.dc_grant, bus.ic_done, bus.dc_done} !== 5'b0 || bus.mem_addr !== 32'h0 || bus.beat_idx !== 3'd0) begin $display("FAIL idle_ready_outputs: got ctl=%b addr=%h beat=%0d want 0", {bus.mem_req, bus.ic_grant, bus.dc_grant, bus.ic_done, bus.dc_done}, bus.mem_addr, bus.beat_idx); n_bad++; end n_cmp++;
         step();
      end
      bus.mem_ready = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_fill();
      test_round_robin();
      test_writeback();
      test_reset_mid_burst();
      test_drop_req();
      test_idle_ready();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8, meaning 32-bit words per cache-line burst (power of 2, 2..16).
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
- CLK  in  1  single clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- ic_req  in  1  I-cache line-fill request; held high until ic_done.
- ic_addr  in  32  I-cache miss address.
- dc_req  in  1  D-cache transaction request; held high until dc_done.
- dc_we  in  1  D-cache type: 1=writeback of dirty line, 0=line fill.
- dc_addr  in  32  D-cache line address.
- dc_wdata  in  32  D-cache writeback word for current beat_idx.
- mem_ready  in  1  memory completed current beat this cycle.
- mem_rdata  in  32  memory read word, valid when mem_ready=1.
- mem_req  out  1  beat request to main memory.
- mem_we  out  1  beat is a write.
- mem_addr  out  32  beat word address.
- mem_wdata  out  32  beat write data.
- ic_grant / dc_grant  out  1  requester owns memory port.
- beat_valid  out  1  mem_rdata forwarded to granted requester this cycle.
- beat_idx  out  log2(LINE_WORDS)  current beat number.
- rdata  out  32  forwarded mem_rdata.
- ic_done / dc_done  out  1  one-cycle transaction-complete pulse.

Function
REQ-003 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, DONE.
REQ-004 IDLE: if only ic_req, go SERVE_I; if only dc_req, go SERVE_D; if both, grant requester not served last (round-robin); if none, stay.
REQ-005 last_served pointer SHALL update on each grant; reset value = D, so first simultaneous conflict grants I.
REQ-006 On IDLE->SERVE_x transition SHALL latch line base = addr[31:log2(LINE_WORDS)+2] and dc_we (I always read); beat counter cleared to 0.
REQ-007 In SERVE_x: mem_req=1, x_grant=1, mem_we = latched we (I: 0), mem_addr = {line base, beat_idx, 2'b00}.
REQ-008 mem_wdata SHALL be combinational pass-through of dc_wdata during SERVE_D write; 0 otherwise.
REQ-009 Beat advances only on mem_ready=1; mem_ready=0 holds address, data, beat_idx (unbounded wait stall).
REQ-010 For reads, beat_valid = mem_ready in SERVE state and rdata = mem_rdata same cycle (zero latency); beat_valid=0 for writes.
REQ-011 mem_ready with beat_idx = LINE_WORDS-1 SHALL move to DONE; beat counter wraps to 0.
REQ-012 DONE: x_done=1 for exactly one cycle, grants deasserted, mem_req=0, next state IDLE; requests ignored in DONE.
REQ-013 Minimum transaction = LINE_WORDS+1 cycles from grant to done; minimum gap between transactions 1 idle cycle (DONE), arbitration re-evaluated in IDLE.
REQ-014 Requester deasserting req mid-burst SHALL NOT abort; burst completes and done pulses.
REQ-015 mem_ready outside SERVE states SHALL be ignored.
REQ-016 ic_grant and dc_grant SHALL never be high simultaneously; done pulses mutually exclusive.
REQ-017 A D writeback followed immediately by D fill (cache re-requests after dc_done) SHALL be treated as two independent transactions subject to round-robin.

Reset
REQ-018 RST_N=0 SHALL asynchronously force IDLE, beat=0, last_served=D, and all outputs 0 (mem_addr, mem_wdata, rdata = 0).
REQ-019 Reset mid-burst SHALL abort immediately with no done pulse; after release, pending reqs arbitrated from IDLE.

Verification
REQ-020 Single I fill: ic_req=1, ic_addr=0x0000_1234, mem_ready=1 every cycle -> mem_addr 0x1220,0x1224..0x123C over 8 cycles, beat_valid each, ic_done pulse on cycle 9 after grant.
REQ-021 Simultaneous ic_req and dc_req after reset -> I granted first; after ic_done and DONE cycle, D granted; next simultaneous conflict grants I again only after D served.
REQ-022 D writeback, dc_addr=0x0000_8000, dc_wdata=0xA0+beat_idx, mem_ready toggling 1,0 -> mem_we=1, 8 writes at 0x8000..0x801C with data 0xA0..0xA7, address held during ready=0 cycles, dc_done after 16 cycles.
REQ-023 RST_N driven low at beat 3 of D fill -> same-cycle mem_req=0, dc_grant=0, no dc_done; after release with dc_req still high, burst restarts at beat 0.
REQ-024 ic_req dropped at beat 2, mem_ready=1 -> burst continues to beat 7, ic_done pulses once, FSM returns IDLE.
REQ-025 mem_ready pulse while IDLE with no requests -> no state change, beat_valid=0, all outputs 0.
